// File: rtl/perceptron_accum.sv
// Perceptron accumulator: sums BEATS 7-bit partial sums per sample, then thresholds the total against thr.
// Optional macro PERCEPTRON_ACCUM_SAT_EN clamps the accumulator at all-ones instead of wrapping.
module perceptron_accum #(
  parameter int BEATS = 4,
  parameter int ACC_W = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [6:0]       in_sum,
  input  logic [ACC_W-1:0] thr,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic             out_class
);

  localparam int CW = $clog2(BEATS + 1);
  localparam logic [CW-1:0] LAST = CW'(BEATS - 1);

  typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

  state_t           state, state_nxt;
  logic [ACC_W-1:0] acc, acc_add;
  logic [CW-1:0]    cnt;
  logic             accept, last, release_out;

  assign in_ready    = (state != DONE);
  assign out_valid   = (state == DONE);
  assign accept      = in_valid && in_ready && !flush;
  assign last        = (cnt == LAST);
  assign release_out = out_valid && out_ready;

`ifdef PERCEPTRON_ACCUM_SAT_EN
  logic [ACC_W:0] sum_ext;
  assign sum_ext = {1'b0, acc} + {{(ACC_W-6){1'b0}}, in_sum};
  // Once clamped, every further add overflows again (or adds 0), so the clamp holds for the sample.
  assign acc_add = sum_ext[ACC_W] ? {ACC_W{1'b1}} : sum_ext[ACC_W-1:0];
`else
  assign acc_add = acc + ACC_W'(in_sum);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, ACC: if (accept) state_nxt = last ? DONE : ACC;
      DONE:      if (out_ready) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
    if (flush) state_nxt = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc       <= '0;
      cnt       <= '0;
      out_sum   <= '0;
      out_class <= 1'b0;
    end else if (flush || release_out) begin
      acc <= '0;
      cnt <= '0;
    end else if (accept) begin
      acc <= acc_add;
      cnt <= cnt + 1'b1;
      if (last) begin
        out_sum   <= acc_add;
        out_class <= (acc_add >= thr);
      end
    end
  end

endmodule
